// File: rtl/ext_int_d_pkg.sv
// Shared I/O constants for the Port D external-interrupt block: register addresses
// and the interrupt sense-control encodings.
package ext_int_d_pkg;

    localparam logic [5:0] EIFR_ADDR_DEF   = 6'h1C;
    localparam logic [5:0] EIMSK_ADDR_DEF  = 6'h1D;
    localparam logic [5:0] PCIFR_ADDR_DEF  = 6'h1B;
    localparam logic [7:0] EICRA_ADDR_DEF  = 8'h69;
    localparam logic [7:0] PCICR_ADDR_DEF  = 8'h68;
    localparam logic [7:0] PCMSK2_ADDR_DEF = 8'h6D;

    localparam logic [1:0] ISC_LOW  = 2'b00;
    localparam logic [1:0] ISC_ANY  = 2'b01;
    localparam logic [1:0] ISC_FALL = 2'b10;
    localparam logic [1:0] ISC_RISE = 2'b11;

    // lvl is the synchronized level, prev the level one cycle earlier.
    function automatic logic edge_match(input logic [1:0] isc, input logic lvl,
                                        input logic prev);
        logic hit;
        case (isc)
            ISC_ANY:  hit = lvl ^ prev;
            ISC_FALL: hit = prev & ~lvl;
            ISC_RISE: hit = ~prev & lvl;
            default:  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ext_int_d_sense.sv
// One INTn pin: three-flop synchronizer, sense-control decode, sticky flag and request.
module ext_int_sense
    import ext_int_d_pkg::*;
(
    input  logic       cp2,
    input  logic       ireset,
    input  logic       pin,
    input  logic [1:0] isc,
    input  logic       int_en,
    input  logic       clr,
    output logic       flag,
    output logic       irq
);

    logic s1_q, s2_q, s3_q;
    logic flag_q, flag_d;
    logic set;

    always_ff @(posedge cp2) begin
        if (!ireset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            s1_q   <= pin;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            flag_q <= flag_d;
        end
    end

    // A hardware set wins over a clear arriving in the same cycle.
    always_comb begin
        set    = edge_match(isc, s2_q, s3_q);
        flag_d = flag_q;
        if (clr) flag_d = 1'b0;
        if (set) flag_d = 1'b1;
    end

    assign flag = flag_q;
    assign irq  = int_en & ((isc == ISC_LOW) ? ~s2_q : flag_q);

endmodule

// File: rtl/ext_int_d.sv
// Port D external interrupts: INT0/INT1 sense units plus the PCINT2 pin-change bank,
// with their I/O and extended data-space control registers.
module ext_int_d
    import ext_int_d_pkg::*;
#(
    parameter logic [5:0] EIFR_ADDR   = EIFR_ADDR_DEF,
    parameter logic [5:0] EIMSK_ADDR  = EIMSK_ADDR_DEF,
    parameter logic [5:0] PCIFR_ADDR  = PCIFR_ADDR_DEF,
    parameter logic [7:0] EICRA_ADDR  = EICRA_ADDR_DEF,
    parameter logic [7:0] PCICR_ADDR  = PCICR_ADDR_DEF,
    parameter logic [7:0] PCMSK2_ADDR = PCMSK2_ADDR_DEF
) (
    input  logic       cp2,
    input  logic       ireset,
    input  logic [5:0] IO_Addr,
    input  logic       iore,
    input  logic       iowe,
    input  logic [7:0] ramadr,
    input  logic       ramre,
    input  logic       ramwe,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    output logic       out_en,
    input  logic [7:0] pinD_i,
    output logic       INT0_EN,
    output logic       INT1_EN,
    output logic       PCIE2,
    output logic [7:0] PCINT,
    output logic [2:0] irq,
    input  logic [2:0] irq_ack
);

    logic [1:0] eimsk_q;
    logic [3:0] eicra_q;
    logic       pcie2_q;
    logic [7:0] pcmsk2_q;
    logic [7:0] pc_s1_q, pc_s2_q, pc_s3_q;
    logic       pcif2_q, pcif2_d;
    logic [1:0] intf;
    logic [1:0] int_irq;
    logic [1:0] int_clr;

    logic wr_eifr, wr_eimsk, wr_pcifr, wr_eicra, wr_pcicr, wr_pcmsk2;

    assign wr_eifr   = iowe  & (IO_Addr == EIFR_ADDR);
    assign wr_eimsk  = iowe  & (IO_Addr == EIMSK_ADDR);
    assign wr_pcifr  = iowe  & (IO_Addr == PCIFR_ADDR);
    assign wr_eicra  = ramwe & (ramadr == EICRA_ADDR);
    assign wr_pcicr  = ramwe & (ramadr == PCICR_ADDR);
    assign wr_pcmsk2 = ramwe & (ramadr == PCMSK2_ADDR);

    assign int_clr = ({2{wr_eifr}} & dbus_in[1:0]) | irq_ack[1:0];

    ext_int_sense u_int0 (
        .cp2    (cp2),
        .ireset (ireset),
        .pin    (pinD_i[2]),
        .isc    (eicra_q[1:0]),
        .int_en (eimsk_q[0]),
        .clr    (int_clr[0]),
        .flag   (intf[0]),
        .irq    (int_irq[0])
    );

    ext_int_sense u_int1 (
        .cp2    (cp2),
        .ireset (ireset),
        .pin    (pinD_i[3]),
        .isc    (eicra_q[3:2]),
        .int_en (eimsk_q[1]),
        .clr    (int_clr[1]),
        .flag   (intf[1]),
        .irq    (int_irq[1])
    );

    always_ff @(posedge cp2) begin
        if (!ireset) begin
            eimsk_q  <= 2'b00;
            eicra_q  <= 4'h0;
            pcie2_q  <= 1'b0;
            pcmsk2_q <= 8'h00;
            pc_s1_q  <= 8'h00;
            pc_s2_q  <= 8'h00;
            pc_s3_q  <= 8'h00;
            pcif2_q  <= 1'b0;
        end else begin
            if (wr_eimsk)  eimsk_q  <= dbus_in[1:0];
            if (wr_eicra)  eicra_q  <= dbus_in[3:0];
            if (wr_pcicr)  pcie2_q  <= dbus_in[2];
            if (wr_pcmsk2) pcmsk2_q <= dbus_in;
            pc_s1_q <= pinD_i;
            pc_s2_q <= pc_s1_q;
            pc_s3_q <= pc_s2_q;
            pcif2_q <= pcif2_d;
        end
    end

    always_comb begin
        pcif2_d = pcif2_q;
        if ((wr_pcifr & dbus_in[2]) | irq_ack[2]) pcif2_d = 1'b0;
        if (|((pc_s2_q ^ pc_s3_q) & pcmsk2_q))    pcif2_d = 1'b1;
    end

    // Reads are gated by reset so nothing leaks onto the shared bus before the first edge.
    always_comb begin
        dbus_out = 8'h00;
        out_en   = 1'b0;
        if (ireset && iore) begin
            if (IO_Addr == EIFR_ADDR) begin
                out_en   = 1'b1;
                dbus_out = {6'b0, intf};
            end else if (IO_Addr == EIMSK_ADDR) begin
                out_en   = 1'b1;
                dbus_out = {6'b0, eimsk_q};
            end else if (IO_Addr == PCIFR_ADDR) begin
                out_en   = 1'b1;
                dbus_out = {5'b0, pcif2_q, 2'b0};
            end
        end
        if (ireset && ramre) begin
            if (ramadr == EICRA_ADDR) begin
                out_en   = 1'b1;
                dbus_out = {4'b0, eicra_q};
            end else if (ramadr == PCICR_ADDR) begin
                out_en   = 1'b1;
                dbus_out = {5'b0, pcie2_q, 2'b0};
            end else if (ramadr == PCMSK2_ADDR) begin
                out_en   = 1'b1;
                dbus_out = pcmsk2_q;
            end
        end
    end

    assign INT0_EN = ireset & eimsk_q[0];
    assign INT1_EN = ireset & eimsk_q[1];
    assign PCIE2   = ireset & pcie2_q;
    assign PCINT   = {8{ireset}} & pcmsk2_q;
    assign irq     = {3{ireset}} & {pcie2_q & pcif2_q, int_irq};

endmodule

// File: tb/tb_ext_int_d.sv
// Scoreboard bench for ext_int_d: directed scenarios followed by random bus/pin traffic,
// all checked against a behavioural model of the interrupt rules.
module tb_ext_int_d;

    logic       cp2;
    logic       ireset;
    logic [5:0] IO_Addr;
    logic       iore, iowe;
    logic [7:0] ramadr;
    logic       ramre, ramwe;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       out_en;
    logic [7:0] pinD_i;
    logic       INT0_EN, INT1_EN, PCIE2;
    logic [7:0] PCINT;
    logic [2:0] irq;
    logic [2:0] irq_ack;

    ext_int_d dut (
        .cp2      (cp2),
        .ireset   (ireset),
        .IO_Addr  (IO_Addr),
        .iore     (iore),
        .iowe     (iowe),
        .ramadr   (ramadr),
        .ramre    (ramre),
        .ramwe    (ramwe),
        .dbus_in  (dbus_in),
        .dbus_out (dbus_out),
        .out_en   (out_en),
        .pinD_i   (pinD_i),
        .INT0_EN  (INT0_EN),
        .INT1_EN  (INT1_EN),
        .PCIE2    (PCIE2),
        .PCINT    (PCINT),
        .irq      (irq),
        .irq_ack  (irq_ack)
    );

    initial begin
        cp2 = 1'b1;
        forever #5 cp2 = ~cp2;
    end

    typedef struct {
        logic [2:0]  irq;
        logic [10:0] en;
    } cyc_t;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } rd_t;

    cyc_t cyc_q[$];
    rd_t  rd_q[$];
    int   push_cnt = 0;
    int   mon_cyc  = 0;
    int   n_err    = 0;
    int   n_checks = 0;

    // Behavioural model: register file plus the pin samples seen at the last three edges.
    logic [1:0] m_eimsk = '0;
    logic [3:0] m_eicra = '0;
    logic       m_pcie2 = 1'b0;
    logic [7:0] m_pcmsk = '0;
    logic [1:0] m_intf  = '0;
    logic       m_pcif  = 1'b0;
    logic [7:0] seen[3] = '{8'h00, 8'h00, 8'h00};

    logic       use_fixed_irq = 1'b0;
    logic [2:0] fixed_irq     = '0;
    logic       use_fixed_rd  = 1'b0;
    logic [7:0] fixed_rd      = '0;

    function automatic bit fires(input logic [1:0] mode, input bit was, input bit now);
        case (mode)
            2'b01:   return was != now;
            2'b10:   return was && !now;
            2'b11:   return !was && now;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] model_irq();
        logic [7:0] lvl;
        logic [2:0] r;
        lvl  = seen[1];
        r[0] = m_eimsk[0] && ((m_eicra[1:0] == 2'b00) ? !lvl[2] : m_intf[0]);
        r[1] = m_eimsk[1] && ((m_eicra[3:2] == 2'b00) ? !lvl[3] : m_intf[1]);
        r[2] = m_pcie2 && m_pcif;
        return ireset ? r : 3'b000;
    endfunction

    function automatic logic [10:0] model_en();
        return ireset ? {m_eimsk[0], m_eimsk[1], m_pcie2, m_pcmsk} : 11'h000;
    endfunction

    task automatic model_read(output logic hit, output logic [7:0] d);
        hit = 1'b0;
        d   = 8'h00;
        if (ireset && iore) begin
            case (IO_Addr)
                6'h1C:   begin hit = 1'b1; d = {6'b0, m_intf}; end
                6'h1D:   begin hit = 1'b1; d = {6'b0, m_eimsk}; end
                6'h1B:   begin hit = 1'b1; d = {5'b0, m_pcif, 2'b0}; end
                default: ;
            endcase
        end
        if (ireset && ramre) begin
            case (ramadr)
                8'h69:   begin hit = 1'b1; d = {4'b0, m_eicra}; end
                8'h68:   begin hit = 1'b1; d = {5'b0, m_pcie2, 2'b0}; end
                8'h6D:   begin hit = 1'b1; d = m_pcmsk; end
                default: ;
            endcase
        end
    endtask

    // Applies the rules to the inputs present at the clock edge.
    task automatic model_edge();
        logic [7:0] lvl, prv;
        bit         hit, clr;
        lvl = seen[1];
        prv = seen[2];
        if (!ireset) begin
            m_eimsk = '0; m_eicra = '0; m_pcie2 = 1'b0; m_pcmsk = '0;
            m_intf  = '0; m_pcif  = 1'b0;
            seen    = '{8'h00, 8'h00, 8'h00};
            return;
        end
        for (int n = 0; n < 2; n++) begin
            hit = fires((n == 0) ? m_eicra[1:0] : m_eicra[3:2],
                        prv[n + 2], lvl[n + 2]);
            clr = (iowe && IO_Addr == 6'h1C && dbus_in[n]) || irq_ack[n];
            if (hit)      m_intf[n] = 1'b1;
            else if (clr) m_intf[n] = 1'b0;
        end
        hit = ((lvl ^ prv) & m_pcmsk) != 8'h00;
        clr = (iowe && IO_Addr == 6'h1B && dbus_in[2]) || irq_ack[2];
        if (hit)      m_pcif = 1'b1;
        else if (clr) m_pcif = 1'b0;
        if (iowe && IO_Addr == 6'h1D)  m_eimsk = dbus_in[1:0];
        if (ramwe && ramadr == 8'h69) m_eicra = dbus_in[3:0];
        if (ramwe && ramadr == 8'h68) m_pcie2 = dbus_in[2];
        if (ramwe && ramadr == 8'h6D) m_pcmsk = dbus_in;
        seen[2] = seen[1];
        seen[1] = seen[0];
        seen[0] = pinD_i;
    endtask

    task automatic idle();
        iore = 1'b0; iowe = 1'b0; ramre = 1'b0; ramwe = 1'b0; irq_ack = 3'b000;
        use_fixed_irq = 1'b0;
        use_fixed_rd  = 1'b0;
    endtask

    // Queues the expectations for the current cycle, then advances one clock.
    task automatic commit();
        cyc_t       ce;
        rd_t        r;
        logic       hit;
        logic [7:0] d;
        ce.irq = use_fixed_irq ? fixed_irq : model_irq();
        ce.en  = model_en();
        cyc_q.push_back(ce);
        model_read(hit, d);
        if (use_fixed_rd || hit) begin
            r.cyc = push_cnt;
            r.d   = use_fixed_rd ? fixed_rd : d;
            rd_q.push_back(r);
        end
        push_cnt++;
        @(posedge cp2);
        model_edge();
        #1;
        idle();
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) commit();
    endtask

    task automatic expect_irq(input logic [2:0] v);
        use_fixed_irq = 1'b1;
        fixed_irq     = v;
    endtask

    task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
        iowe = 1'b1; IO_Addr = a; dbus_in = d;
        commit();
    endtask

    task automatic ram_wr(input logic [7:0] a, input logic [7:0] d);
        ramwe = 1'b1; ramadr = a; dbus_in = d;
        commit();
    endtask

    task automatic io_rd(input logic [5:0] a, input logic [7:0] exp);
        iore = 1'b1; IO_Addr = a;
        use_fixed_rd = 1'b1; fixed_rd = exp;
        commit();
    endtask

    task automatic ram_rd(input logic [7:0] a, input logic [7:0] exp);
        ramre = 1'b1; ramadr = a;
        use_fixed_rd = 1'b1; fixed_rd = exp;
        commit();
    endtask

    // Monitor: every cycle has an irq/enable expectation; reads are popped when presented.
    always @(negedge cp2) begin
        cyc_t ce;
        rd_t  r;
        bit   exp_rd;
        if (cyc_q.size() != 0) begin
            ce = cyc_q.pop_front();
            check("irq", {13'b0, irq}, {13'b0, ce.irq});
            check("enables", {5'b0, INT0_EN, INT1_EN, PCIE2, PCINT}, {5'b0, ce.en});
            exp_rd = (rd_q.size() != 0) && (rd_q[0].cyc == mon_cyc);
            check("out_en", {15'b0, out_en}, {15'b0, exp_rd});
            if (exp_rd) begin
                r = rd_q.pop_front();
                if (out_en) check("rdata", {8'b0, dbus_out}, {8'b0, r.d});
            end else begin
                check("idle_dbus", {8'b0, dbus_out}, 16'h0000);
            end
            mon_cyc++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rnd;
        ireset = 1'b0; IO_Addr = '0; ramadr = '0; dbus_in = '0; pinD_i = 8'hFF;
        idle();
        wait_n(3);
        ireset = 1'b1;
        wait_n(4);

        // Falling edge on INT0, then cleared by acknowledge.
        ram_wr(8'h69, 8'h02);
        io_wr(6'h1D, 8'h01);
        pinD_i[2] = 1'b0;
        wait_n(2);
        expect_irq(3'b000); commit();
        expect_irq(3'b001); io_rd(6'h1C, 8'h01);
        irq_ack = 3'b001; expect_irq(3'b001); commit();
        expect_irq(3'b000); io_rd(6'h1C, 8'h00);

        // Level-low INT1 follows the pin and never sets its flag.
        pinD_i[2] = 1'b1;
        ram_wr(8'h69, 8'h00);
        io_wr(6'h1D, 8'h02);
        wait_n(3);
        pinD_i[3] = 1'b0;
        expect_irq(3'b000); commit();
        expect_irq(3'b000); commit();
        expect_irq(3'b010); io_rd(6'h1C, 8'h00);
        irq_ack = 3'b010; expect_irq(3'b010); commit();
        pinD_i[3] = 1'b1;
        expect_irq(3'b010); commit();
        expect_irq(3'b010); commit();
        expect_irq(3'b000); commit();

        // Pin-change bank: only masked pins raise PCIF2.
        io_wr(6'h1D, 8'h00);
        ram_wr(8'h6D, 8'h81);
        ram_wr(8'h68, 8'h04);
        pinD_i[4] = ~pinD_i[4];
        wait_n(4);
        expect_irq(3'b000); io_rd(6'h1B, 8'h00);
        pinD_i[7] = ~pinD_i[7];
        wait_n(3);
        expect_irq(3'b100); io_rd(6'h1B, 8'h04);
        io_wr(6'h1B, 8'h04);
        expect_irq(3'b000); io_rd(6'h1B, 8'h00);

        // Write-1 clear colliding with a new falling edge leaves INTF0 set.
        ram_wr(8'h68, 8'h00);
        ram_wr(8'h6D, 8'h00);
        ram_wr(8'h69, 8'h02);
        io_wr(6'h1D, 8'h01);
        pinD_i[2] = 1'b0;
        wait_n(3);
        io_rd(6'h1C, 8'h01);
        pinD_i[2] = 1'b1;
        wait_n(4);
        pinD_i[2] = 1'b0;
        wait_n(2);
        io_wr(6'h1C, 8'h01);
        expect_irq(3'b001); io_rd(6'h1C, 8'h01);
        io_wr(6'h1C, 8'h01);
        expect_irq(3'b000); io_rd(6'h1C, 8'h00);

        // Any-change with INT0 masked: flag set, request only once unmasked.
        io_wr(6'h1D, 8'h00);
        ram_wr(8'h69, 8'h01);
        pinD_i[2] = 1'b1; commit();
        pinD_i[2] = 1'b0;
        wait_n(4);
        expect_irq(3'b000); io_rd(6'h1C, 8'h01);
        expect_irq(3'b000); io_wr(6'h1D, 8'h01);
        expect_irq(3'b001); io_rd(6'h1C, 8'h01);
        io_wr(6'h1C, 8'h01);
        io_wr(6'h1D, 8'h00);

        // Reset with INTF1 pending and a PD3 edge still in the synchronizer.
        ram_wr(8'h69, 8'h04);
        io_wr(6'h1D, 8'h02);
        ram_wr(8'h6D, 8'h08);
        ram_wr(8'h68, 8'h04);
        pinD_i[3] = ~pinD_i[3];
        wait_n(3);
        expect_irq(3'b110); io_rd(6'h1C, 8'h02);
        pinD_i[3] = ~pinD_i[3];
        commit();
        ireset = 1'b0;
        wait_n(2);
        ireset = 1'b1;
        expect_irq(3'b000); io_rd(6'h1C, 8'h00);
        expect_irq(3'b000); io_rd(6'h1D, 8'h00);
        expect_irq(3'b000); io_rd(6'h1B, 8'h00);
        expect_irq(3'b000); ram_rd(8'h69, 8'h00);
        expect_irq(3'b000); ram_rd(8'h6D, 8'h00);
        expect_irq(3'b000); ram_rd(8'h68, 8'h00);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rnd = $urandom;
            if ($urandom_range(0, 3) == 0) pinD_i = pinD_i ^ (8'h01 << $urandom_range(0, 7));
            ireset  = ($urandom_range(0, 199) != 0);
            dbus_in = rnd[7:0];
            if ($urandom_range(0, 9) == 0) irq_ack = rnd[10:8];
            case ($urandom_range(0, 7))
                0: begin iowe = 1'b1; IO_Addr = (rnd[13]) ? 6'h1C : 6'h1B; end
                1: begin iowe = 1'b1; IO_Addr = 6'h1D; end
                2: begin ramwe = 1'b1;
                         case (rnd[15:14])
                             2'd0:    ramadr = 8'h69;
                             2'd1:    ramadr = 8'h68;
                             2'd2:    ramadr = 8'h6D;
                             default: ramadr = rnd[23:16];
                         endcase
                   end
                3, 4: begin iore = 1'b1;
                         case (rnd[15:14])
                             2'd0:    IO_Addr = 6'h1C;
                             2'd1:    IO_Addr = 6'h1D;
                             2'd2:    IO_Addr = 6'h1B;
                             default: IO_Addr = rnd[21:16];
                         endcase
                   end
                5: begin ramre = 1'b1;
                         case (rnd[15:14])
                             2'd0:    ramadr = 8'h69;
                             2'd1:    ramadr = 8'h68;
                             2'd2:    ramadr = 8'h6D;
                             default: ramadr = rnd[23:16];
                         endcase
                   end
                default: ;
            endcase
            commit();
        end
        ireset = 1'b1;
        wait_n(2);
        @(negedge cp2);
        #1;
        check("queues_drained", 16'(cyc_q.size() + rd_q.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
